addsub_seq: RTL and testbench

- Parametrised, multi-cycle adder/subtractor for the datapath library. It generalises the fixed 8-bit combinational add/sub.
- Adds configurable width, chunked (digit-serial) evaluation, signed saturation modes, and status flags.
- Uses a valid/ready handshake on input and output, so it drops into streaming pipelines and trades area for latency.

---
 rtl/addsub_pkg.sv | 29 ++
 rtl/addsub_seq_if.sv | 27 ++
 rtl/addsub_chunk.sv | 14 +
 rtl/addsub_seq.sv | 157 +++++++++++++++
 tb/tb_addsub_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: op codes, FSM states
// and signed saturation limits.
package addsub_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDS = 2'b10;
    localparam logic [1:0] OP_SUBS = 2'b11;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Largest positive two's-complement value of width w, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    // Most negative two's-complement value of width w (only bit w-1 set).
    function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Valid/ready request and response bundle for addsub_seq.
interface addsub_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative
    );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple slice; reused every cycle for the next digit.
module addsub_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    localparam int unsigned SW = CHUNK + 1;

    assign {cout, sum} = SW'(x) + SW'(y) + SW'(cin);
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract with signed saturation and status flags; operands are
// consumed one CHUNK-bit digit per cycle, LSB digit first.
module addsub_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input logic         clk,
    input logic         rst,
    addsub_seq_if.slave bus
);
    import addsub_pkg::*;

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned MSB    = WIDTH - 1;
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (WIDTH < 2 || CHUNK == 0 || WIDTH > MAX_W || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("addsub_seq: WIDTH must be in 2..64 and a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] raw_q, raw_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;

    int unsigned      base_c;
    logic [CHUNK-1:0] x_c, y_c, sum_c;
    logic             cout_c;
    logic             ovf_c;
    logic [WIDTH-1:0] final_c;

    assign base_c = 32'(idx_q) * CHUNK;
    assign x_c    = a_q[base_c +: CHUNK];
    assign y_c    = b_q[base_c +: CHUNK];

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x   (x_c),
        .y   (y_c),
        .cin (cy_q),
        .sum (sum_c),
        .cout(cout_c)
    );

    // Overflow is judged on the raw sum; saturation direction follows the sign of a.
    assign ovf_c   = (a_q[MSB] == b_q[MSB]) && (raw_q[MSB] != a_q[MSB]);
    assign final_c = (op_q[1] && ovf_c) ? (a_q[MSB] ? SAT_MIN : SAT_MAX) : raw_q;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        idx_d      = idx_q;
        cy_d       = cy_q;
        raw_d      = raw_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.op[0] ? ~bus.b : bus.b;
                    op_d    = bus.op;
                    idx_d   = '0;
                    cy_d    = bus.op[0];
                    raw_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                raw_d[base_c +: CHUNK] = sum_c;
                cy_d = cout_c;
                if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FINISH: begin
                result_d   = final_c;
                carry_d    = cy_q;
                overflow_d = ovf_c;
                zero_d     = (final_c == '0);
                negative_d = final_c[MSB];
                state_d    = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            cy_q        <= 1'b0;
            raw_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            cy_q        <= cy_d;
            raw_q       <= raw_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq (WIDTH=8, CHUNK=4): directed table, random ops against an
// integer-arithmetic reference, backpressure and mid-operation reset sequences.
module tb_addsub_seq;

    localparam int unsigned W  = 8;
    localparam int unsigned CH = 4;
    localparam int LAT = W / CH + 1;

    typedef struct {
        logic [7:0] result;
        logic       carry;
        logic       overflow;
        logic       zero;
        logic       negative;
    } res_t;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        res_t       exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    addsub_seq_if #(.WIDTH(W)) bus ();

    addsub_seq #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then clamp / wrap to 8 bits.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        res_t r;
        int sa, sb, ua, ub, t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        if (op[0]) begin
            t = sa - sb;
            r.carry = (ua >= ub);
        end else begin
            t = sa + sb;
            r.carry = (ua + ub) > 255;
        end
        r.overflow = (t > 127) || (t < -128);
        if (op[1] && t > 127)  t = 127;
        if (op[1] && t < -128) t = -128;
        r.result   = 8'(t);
        r.zero     = (r.result == 8'h00);
        r.negative = r.result[7];
        return r;
    endfunction

    function automatic res_t sample();
        res_t r;
        r.result   = bus.result;
        r.carry    = bus.carry;
        r.overflow = bus.overflow;
        r.zero     = bus.zero;
        r.negative = bus.negative;
        return r;
    endfunction

    task automatic chk_res(input string name, input res_t got, input res_t exp);
        chk({name, ".result"},   32'(got.result),   32'(exp.result));
        chk({name, ".carry"},    32'(got.carry),    32'(exp.carry));
        chk({name, ".overflow"}, 32'(got.overflow), 32'(exp.overflow));
        chk({name, ".zero"},     32'(got.zero),     32'(exp.zero));
        chk({name, ".negative"}, 32'(got.negative), 32'(exp.negative));
    endtask

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         output int lat, output res_t got);
        int k;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a  = a;
        bus.b  = b;
        bus.op = op;
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        lat = k;
        got = sample();
    endtask

    vec_t vecs[$];

    initial begin
        res_t got, exp, held;
        int   lat;
        n_chk  = 0;
        n_fail = 0;

        vecs.push_back('{"add_3c_05",   8'h3C, 8'h05, 2'b00, '{8'h41, 1'b0, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{"sub_05_05",   8'h05, 8'h05, 2'b01, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{"sub_00_01",   8'h00, 8'h01, 2'b01, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1}});
        vecs.push_back('{"add_7f_01",   8'h7F, 8'h01, 2'b00, '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1}});
        vecs.push_back('{"adds_7f_01",  8'h7F, 8'h01, 2'b10, '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{"subs_80_01",  8'h80, 8'h01, 2'b11, '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1}});
        vecs.push_back('{"sub_80_01",   8'h80, 8'h01, 2'b01, '{8'h7F, 1'b1, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{"add_ff_01",   8'hFF, 8'h01, 2'b00, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{"adds_80_80",  8'h80, 8'h80, 2'b10, '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1}});
        vecs.push_back('{"subs_00_80",  8'h00, 8'h80, 2'b11, '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{"adds_10_20",  8'h10, 8'h20, 2'b10, '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0}});

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a  = '0;
        bus.b  = '0;
        bus.op = '0;
        repeat (3) @(negedge clk);
        chk("reset.in_ready",  32'(bus.in_ready),  32'd1);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk_res("reset", sample(), '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        @(negedge clk);

        // Directed table: value, latency, single-cycle valid, ready returns.
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op, lat, got);
            chk({vecs[i].name, ".latency"}, 32'(lat), 32'(LAT));
            chk({vecs[i].name, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
            chk_res(vecs[i].name, got, vecs[i].exp);
            @(negedge clk);
            chk({vecs[i].name, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
            chk({vecs[i].name, ".ready_back"}, 32'(bus.in_ready),  32'd1);
        end

        // Random operations against the reference.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            logic [1:0] rop;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 2'($urandom);
            issue(ra, rb, rop, lat, got);
            chk("rand.latency", 32'(lat), 32'(LAT));
            chk_res($sformatf("rand%0d_%02h_%02h_op%0d", i, ra, rb, rop), got, model(ra, rb, rop));
            @(negedge clk);
        end

        // Backpressure: output held, new request ignored, single transfer on release.
        bus.out_ready = 1'b0;
        issue(8'h12, 8'h34, 2'b00, lat, held);
        chk("bp.latency", 32'(lat), 32'(LAT));
        chk_res("bp.first", held, '{8'h46, 1'b0, 1'b0, 1'b0, 1'b0});
        bus.in_valid = 1'b1;
        bus.a  = 8'h11;
        bus.b  = 8'h01;
        bus.op = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.out_valid_held", 32'(bus.out_valid), 32'd1);
            chk("bp.in_ready_low",   32'(bus.in_ready),  32'd0);
            chk_res("bp.hold", sample(), '{8'h46, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp.single_transfer", 32'(bus.out_valid), 32'd0);
        chk("bp.ready_back",      32'(bus.in_ready),  32'd1);
        issue(8'h11, 8'h22, 2'b00, lat, got);
        chk("bp.next.latency", 32'(lat), 32'(LAT));
        chk_res("bp.next", got, '{8'h33, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);

        // Reset one cycle into CALC aborts the op with no output.
        bus.in_valid = 1'b1;
        bus.a  = 8'hFF;
        bus.b  = 8'hFF;
        bus.op = 2'b00;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid.in_ready",  32'(bus.in_ready),  32'd1);
        chk_res("rst_mid", sample(), '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid.no_output", 32'(bus.out_valid), 32'd0);
        end
        issue(8'h01, 8'h02, 2'b00, lat, got);
        chk("rst_after.latency", 32'(lat), 32'(LAT));
        chk_res("rst_after", got, '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
